// File: rtl/clk_div_cfg_ctrl.sv
// Configuration sequencer for the UART clock divider: holds the divider disabled
// long enough to drain a partial period before loading a new ratio, then re-enables it.
module clk_div_cfg_ctrl #(
  parameter int         QUIESCE_CYC = 16,
  parameter int         SETTLE_CYC  = 4,
  parameter int         CNT_W       = 5,
  parameter logic [3:0] RESET_RATIO = 4'd1
) (
  input  logic       I_ref_clk,
  input  logic       I_rst_n,
  input  logic       I_req,
  input  logic       I_mode,
  input  logic [3:0] I_ratio,
  input  logic [5:0] I_prescale,
  output logic       O_ack,
  output logic       O_done,
  output logic       O_err,
  output logic       O_busy,
  output logic       O_clk_en,
  output logic [3:0] O_div_ratio
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SETTLE
  } state_t;

  localparam logic [CNT_W-1:0] QUIESCE_LAST = CNT_W'(QUIESCE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       target_q, target_d;
  logic [3:0]       ratio_d;
  logic             clk_en_d, busy_d, ack_d, done_d, err_d;

  logic             req_legal;
  logic [3:0]       req_target;

  // Prescale mode maps the UART oversampling factor onto the divider ratio.
  always_comb begin
    req_legal  = 1'b1;
    req_target = I_ratio;
    if (I_mode) begin
      unique case (I_prescale)
        6'd32:   req_target = 4'd1;
        6'd16:   req_target = 4'd2;
        6'd8:    req_target = 4'd4;
        default: begin
          req_legal  = 1'b0;
          req_target = 4'd0;
        end
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    ratio_d  = O_div_ratio;
    clk_en_d = O_clk_en;
    busy_d   = O_busy;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (I_req) begin
          if (!req_legal) begin
            err_d = 1'b1;
          end else if (req_target == O_div_ratio) begin
            ack_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            target_d = req_target;
            ack_d    = 1'b1;
            clk_en_d = 1'b0;
            busy_d   = 1'b1;
            cnt_d    = '0;
            state_d  = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (cnt_q == QUIESCE_LAST) begin
          ratio_d = target_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          clk_en_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock
  // edge, so an aborted sequence simply returns to IDLE with no done pulse.
  always_ff @(posedge I_ref_clk) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      target_q    <= RESET_RATIO;
      O_div_ratio <= RESET_RATIO;
      O_clk_en    <= 1'b1;
      O_busy      <= 1'b0;
      O_ack       <= 1'b0;
      O_done      <= 1'b0;
      O_err       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      O_div_ratio <= ratio_d;
      O_clk_en    <= clk_en_d;
      O_busy      <= busy_d;
      O_ack       <= ack_d;
      O_done      <= done_d;
      O_err       <= err_d;
    end
  end

endmodule

// File: doc/clk_div_cfg_ctrl.md
# clk_div_cfg_ctrl

Configuration sequencer for the UART clock divider. It accepts ratio-change requests from the register-file side and drives the divider's enable and ratio inputs. A new ratio is applied only after the divider has been held disabled long enough to drain any partial output period, so ratio changes cannot create runt pulses on the divided clock. It sits between the register file / system controller and the divider instance in the clock-and-power domain, and runs on the divider's reference clock.

## Interface
- QUIESCE_CYC, 16: cycles the divider stays disabled before the new ratio is loaded; ≥ 15 (max 4-bit ratio) and ≥ 1
- SETTLE_CYC, 4: cycles the divider stays disabled after the new ratio is loaded; ≥ 1
- CNT_W, 5: phase-counter width; must hold max(QUIESCE_CYC, SETTLE_CYC)
- RESET_RATIO, 4'd1: ratio driven after reset (1 = bypass)

- I_ref_clk  in  1  reference clock, the same clock as the divider
- I_rst_n  in  1  reset, synchronous, active-low
- I_req  in  1  level request; held until O_ack or O_err
- I_mode  in  1  0: use I_ratio directly; 1: derive ratio from I_prescale
- I_ratio  in  4  requested raw ratio; all 16 values legal
- I_prescale  in  6  UART prescale; only 32, 16 and 8 are legal
- O_ack  out  1  one-cycle pulse: request accepted
- O_done  out  1  one-cycle pulse: new ratio active, divider re-enabled
- O_err  out  1  one-cycle pulse: request rejected (illegal prescale)
- O_busy  out  1  high from the cycle after acceptance until O_done
- O_clk_en  out  1  divider enable
- O_div_ratio  out  4  divider ratio

## Operation
- Target ratio:
  - I_mode=0: target = I_ratio.
  - I_mode=1: prescale 32→1, 16→2, 8→4; any other value is illegal.
- State IDLE: O_clk_en=1, O_busy=0. On I_req=1:
  - Illegal target: O_err pulse; stay in IDLE; O_div_ratio and O_clk_en unchanged.
  - Target == O_div_ratio: O_ack and O_done pulse in the same cycle; stay in IDLE; O_clk_en stays 1.
  - Otherwise: latch target, O_ack pulse, O_clk_en←0, O_busy←1, counter←0, go to DRAIN.
- State DRAIN: hold O_clk_en=0 for QUIESCE_CYC cycles.
  - On the last cycle: O_div_ratio←latched target, counter←0, go to SETTLE.
- State SETTLE: hold O_clk_en=0 for SETTLE_CYC cycles.
  - On the last cycle: O_clk_en←1, O_busy←0, O_done pulse, go to IDLE.
- I_req during DRAIN/SETTLE: ignored, no ack. Input changes there do not affect the latched target.
- I_req still high in the IDLE cycle after an ack is a new request. Requesters drop I_req on the cycle they see O_ack or O_err.
- O_ack, O_done and O_err are mutually exclusive except in the same-ratio case (ack+done together).
- Reset (I_rst_n=0 at a clock edge), including mid-sequence:
  - State → IDLE; O_div_ratio=RESET_RATIO; O_clk_en=1; O_busy=0.
  - O_ack, O_done and O_err all 0; no done pulse is generated for the aborted sequence.

## Timing
- All outputs are registered.
- Request sampled at edge T in IDLE: O_ack=1, O_busy=1 and O_clk_en=0 are visible in cycle T+1.
- O_div_ratio shows the new value from cycle T+1+QUIESCE_CYC.
- O_done=1, O_clk_en=1 and O_busy=0 are visible in cycle T+1+QUIESCE_CYC+SETTLE_CYC.
- Total request-to-done latency: QUIESCE_CYC+SETTLE_CYC+1 cycles (21 with defaults).
- Same-ratio and illegal requests respond in cycle T+1, with one cycle of latency.
- O_div_ratio never changes while O_clk_en=1.
- O_clk_en is low for exactly QUIESCE_CYC+SETTLE_CYC consecutive cycles per accepted change.
- Counter wrap: the counter compares against the parameter minus 1, so no counter overflow is reachable within CNT_W.

## Test plan
- Reset with default parameters, then I_mode=0, I_ratio=8 held until ack:
  - O_ack at cycle 1; O_clk_en=0 for cycles 1–20; O_div_ratio=8 from cycle 17.
  - O_done together with O_clk_en=1 at cycle 21.
- Current ratio 8, I_mode=1, I_prescale=16: ratio 2 is applied after 21 cycles. Repeat with prescale 32 → ratio 1, and prescale 8 → ratio 4.
- I_mode=1, I_prescale=12: O_err pulse at cycle 1; no O_ack; O_clk_en stays 1; O_div_ratio unchanged.
- Current ratio 4, request I_ratio=4:
  - O_ack and O_done in the same cycle; O_clk_en never drops.
- During DRAIN, toggle I_req and change I_ratio from 6 to 3 (original target 6):
  - No extra O_ack; final O_div_ratio=6; a new request is accepted only after O_done.
- Assert I_rst_n=0 at cycle 10 of a change to 8 from RESET_RATIO:
  - Next cycle: O_div_ratio=1, O_clk_en=1, O_busy=0; no O_done is ever produced for the aborted change.
